// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transaction controller.
package usb_pkg;

    // Packet type requested from the transmit path
    typedef enum logic [1:0] {
        PT_NONE  = 2'b00,
        PT_TOKEN = 2'b01,
        PT_DATA  = 2'b10,
        PT_HS    = 2'b11
    } pkt_type_e;

    // PID encodings used by the controller
    localparam logic [3:0] PID_NONE  = 4'b0000;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    // Transaction result codes
    typedef enum logic [1:0] {
        RES_OK      = 2'b00,
        RES_NAK     = 2'b01,
        RES_TIMEOUT = 2'b10,
        RES_BAD     = 2'b11
    } result_e;

    // Transaction state machine states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_TOK  = 3'd1,
        ST_TX_DATA = 3'd2,
        ST_RX_WAIT = 3'd3,
        ST_TX_HS   = 3'd4,
        ST_FIN     = 3'd5
    } txn_state_e;

    // True for either data packet PID
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_rx_timer.sv
// Receive-wait timer: 8-bit counter with clear, increment, saturation
// at 8'hFF and a timeout flag once the count reaches the limit.
module usb_rx_timer (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [7:0] limit_i,
    output logic       timeout_o
);

    logic [7:0] count_q, count_d;

    // Clear has priority; increment stops at the all-ones value
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'd0;
        end else if (inc_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_b) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = (count_q >= limit_i);

endmodule

// File: rtl/usb_txn_ctrl.sv
// USB host transaction controller: sequences token, data and handshake
// packets for IN/OUT transactions and reports the outcome.
// Optional feature macro USB_TXN_RETRY_EN: when defined, NAK, TIMEOUT
// and BAD outcomes restart the transaction until MAX_TRIES attempts.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYC = 8'd200,
    parameter logic [2:0] MAX_TRIES   = 3'd4
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic       txn_in,
    input  logic       tx_done,
    input  logic       rx_done,
    input  logic [3:0] rx_pid,
    input  logic       rx_crc_ok,
    output logic       tx_req,
    output logic [1:0] tx_ptype,
    output logic [3:0] tx_pid,
    output logic       rw,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] result,
    output logic [2:0] tries
);

`ifdef USB_TXN_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    txn_state_e state_q, state_d;
    result_e    result_q, result_d;
    result_e    outcome;
    logic       have_outcome;
    logic       is_in_q, is_in_d;
    logic [2:0] tries_q, tries_d;
    logic       tx_req_q, tx_req_d;
    logic       timeout;

    usb_rx_timer u_rx_timer (
        .clk       (clk),
        .rst_b     (rst_b),
        .clr_i     (state_q != ST_RX_WAIT),
        .inc_i     ((state_q == ST_RX_WAIT) && !rx_done),
        .limit_i   (TIMEOUT_CYC),
        .timeout_o (timeout)
    );

    // State and transaction context registers
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q  <= ST_IDLE;
            result_q <= RES_OK;
            is_in_q  <= 1'b0;
            tries_q  <= 3'd0;
            tx_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            is_in_q  <= is_in_d;
            tries_q  <= tries_d;
            tx_req_q <= tx_req_d;
        end
    end

    // Next-state logic; failed outcomes either restart the attempt or finish
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        is_in_d      = is_in_q;
        tries_d      = tries_q;
        have_outcome = 1'b0;
        outcome      = RES_OK;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_in_d = txn_in;
                    tries_d = 3'd1;
                    state_d = ST_TX_TOK;
                end
            end
            ST_TX_TOK: begin
                if (tx_done) begin
                    state_d = is_in_q ? ST_RX_WAIT : ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                if (tx_done) begin
                    state_d = ST_RX_WAIT;
                end
            end
            ST_RX_WAIT: begin
                if (rx_done) begin
                    if (is_in_q) begin
                        if (is_data_pid(rx_pid)) begin
                            if (rx_crc_ok) begin
                                state_d = ST_TX_HS;
                            end else begin
                                have_outcome = 1'b1;
                                outcome      = RES_BAD;
                            end
                        end else if (rx_pid == PID_NAK) begin
                            have_outcome = 1'b1;
                            outcome      = RES_NAK;
                        end else begin
                            have_outcome = 1'b1;
                            outcome      = RES_BAD;
                        end
                    end else begin
                        if (rx_pid == PID_ACK) begin
                            result_d = RES_OK;
                            state_d  = ST_FIN;
                        end else if (rx_pid == PID_NAK) begin
                            have_outcome = 1'b1;
                            outcome      = RES_NAK;
                        end else begin
                            have_outcome = 1'b1;
                            outcome      = RES_BAD;
                        end
                    end
                end else if (timeout) begin
                    have_outcome = 1'b1;
                    outcome      = RES_TIMEOUT;
                end
            end
            ST_TX_HS: begin
                if (tx_done) begin
                    result_d = RES_OK;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (have_outcome) begin
            if (RETRY_EN && (tries_q < MAX_TRIES)) begin
                tries_d = tries_q + 3'd1;
                state_d = ST_TX_TOK;
            end else begin
                result_d = outcome;
                state_d  = ST_FIN;
            end
        end
        tx_req_d = (state_d != state_q) &&
                   ((state_d == ST_TX_TOK) || (state_d == ST_TX_DATA) ||
                    (state_d == ST_TX_HS));
    end

    // Outputs decoded from the current state
    always_comb begin
        tx_req       = tx_req_q;
        tx_ptype     = PT_NONE;
        tx_pid       = PID_NONE;
        rw           = 1'b1;
        busy         = (state_q != ST_IDLE);
        result_valid = (state_q == ST_FIN);
        result       = result_q;
        tries        = tries_q;
        case (state_q)
            ST_TX_TOK: begin
                tx_ptype = PT_TOKEN;
                tx_pid   = is_in_q ? PID_IN : PID_OUT;
            end
            ST_TX_DATA: begin
                tx_ptype = PT_DATA;
            end
            ST_TX_HS: begin
                tx_ptype = PT_HS;
                tx_pid   = PID_ACK;
            end
            ST_RX_WAIT: begin
                rw = 1'b0;
            end
            default: begin
                tx_ptype = PT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Scoreboard bench for usb_txn_ctrl: stimulus pushes expected packet
// requests and results, a monitor pops and compares them as they appear.
module tb_usb_txn_ctrl;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       start = 1'b0;
    logic       txn_in = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [3:0] rx_pid = 4'd0;
    logic       rx_crc_ok = 1'b0;
    logic       tx_req;
    logic [1:0] tx_ptype;
    logic [3:0] tx_pid;
    logic       rw;
    logic       busy;
    logic       result_valid;
    logic [1:0] result;
    logic [2:0] tries;

    typedef struct packed {
        logic [1:0] ptype;
        logic [3:0] pid;
    } tx_exp_t;

    typedef struct packed {
        logic [1:0] res;
        logic [2:0] tries;
    } res_exp_t;

    tx_exp_t  txExp[$];
    res_exp_t resExp[$];
    tx_exp_t  monTx;
    res_exp_t monRes;
    int nVectors = 0;
    int nMiscompares = 0;

    usb_txn_ctrl dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start        (start),
        .txn_in       (txn_in),
        .tx_done      (tx_done),
        .rx_done      (rx_done),
        .rx_pid       (rx_pid),
        .rx_crc_ok    (rx_crc_ok),
        .tx_req       (tx_req),
        .tx_ptype     (tx_ptype),
        .tx_pid       (tx_pid),
        .rw           (rw),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .tries        (tries)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every packet request and every result is matched in order
    always @(negedge clk) begin
        if (tx_req) begin
            if (txExp.size() == 0) begin
                checkOutput("tx_req_unexpected", 32'(tx_req), 32'd0);
            end else begin
                monTx = txExp.pop_front();
                checkOutput("tx_ptype", 32'(tx_ptype), 32'(monTx.ptype));
                checkOutput("tx_pid", 32'(tx_pid), 32'(monTx.pid));
                checkOutput("tx_rw", 32'(rw), 32'd1);
            end
        end
        if (result_valid) begin
            if (resExp.size() == 0) begin
                checkOutput("result_valid_unexpected", 32'(result_valid), 32'd0);
            end else begin
                monRes = resExp.pop_front();
                checkOutput("result", 32'(result), 32'(monRes.res));
                checkOutput("tries", 32'(tries), 32'(monRes.tries));
            end
        end
    end

    // Inputs change 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic isIn);
        start  = 1'b1;
        txn_in = isIn;
        tick();
        start  = 1'b0;
        txn_in = 1'b0;
    endtask

    task automatic pulseTxDone();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulseRx(input logic [3:0] pid, input logic crcOk);
        rx_pid    = pid;
        rx_crc_ok = crcOk;
        rx_done   = 1'b1;
        tick();
        rx_done   = 1'b0;
        rx_pid    = 4'd0;
        rx_crc_ok = 1'b0;
    endtask

    task automatic waitTxReq();
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("wait_tx_req", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        checkOutput("wait_idle", 32'(idle), 32'd1);
        tick();
    endtask

    // One OUT attempt: token then data, leaving the DUT in RX_WAIT
    task automatic outAttempt();
        txExp.push_back(tx_exp_t'{PT_TOKEN, PID_OUT});
        waitTxReq();
        pulseTxDone();
        txExp.push_back(tx_exp_t'{PT_DATA, PID_NONE});
        waitTxReq();
        pulseTxDone();
    endtask

    // OUT transaction whose first response is a failing PID
    task automatic outFailing(input logic [3:0] pid, input logic [1:0] expRes);
`ifdef USB_TXN_RETRY_EN
        resExp.push_back(res_exp_t'{RES_OK, 3'd2});
        pulseStart(1'b0);
        outAttempt();
        pulseRx(pid, 1'b1);
        outAttempt();
        pulseRx(PID_ACK, 1'b1);
        checkOutput("retry_expres_unused", 32'(expRes), 32'(expRes));
`else
        resExp.push_back(res_exp_t'{expRes, 3'd1});
        pulseStart(1'b0);
        outAttempt();
        pulseRx(pid, 1'b1);
`endif
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rst_tx_req", 32'(tx_req), 32'd0);
        checkOutput("rst_tx_ptype", 32'(tx_ptype), 32'd0);
        checkOutput("rst_tx_pid", 32'(tx_pid), 32'd0);
        checkOutput("rst_rw", 32'(rw), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_tries", 32'(tries), 32'd0);
        tick();
        rst_b = 1'b0;
        tick();

        // OUT with immediate ACK, including latency and hold checks
        $display("[TB] OUT transaction acknowledged");
        resExp.push_back(res_exp_t'{RES_OK, 3'd1});
        txExp.push_back(tx_exp_t'{PT_TOKEN, PID_OUT});
        pulseStart(1'b0);
        waitTxReq();
        @(negedge clk);
        checkOutput("tok_hold_ptype", 32'(tx_ptype), 32'(PT_TOKEN));
        checkOutput("tok_req_one_cycle", 32'(tx_req), 32'd0);
        checkOutput("tok_busy", 32'(busy), 32'd1);
        tick();
        pulseTxDone();
        txExp.push_back(tx_exp_t'{PT_DATA, PID_NONE});
        waitTxReq();
        pulseTxDone();
        @(negedge clk);
        checkOutput("rxwait_rw", 32'(rw), 32'd0);
        checkOutput("rxwait_ptype", 32'(tx_ptype), 32'd0);
        tick();
        pulseRx(PID_ACK, 1'b1);
        @(negedge clk);
        checkOutput("ack_latency", 32'(result_valid), 32'd1);
        tick();
        waitIdle();

        // IN with DATA0 and good CRC; a stray tx_done in RX_WAIT is ignored
        $display("[TB] IN transaction with handshake");
        resExp.push_back(res_exp_t'{RES_OK, 3'd1});
        txExp.push_back(tx_exp_t'{PT_TOKEN, PID_IN});
        pulseStart(1'b1);
        waitTxReq();
        pulseTxDone();
        pulseTxDone();
        tick();
        txExp.push_back(tx_exp_t'{PT_HS, PID_ACK});
        pulseRx(PID_DATA0, 1'b1);
        waitTxReq();
        pulseTxDone();
        waitIdle();

        // IN with DATA1 and bad CRC: no handshake
        $display("[TB] IN transaction with bad CRC");
        txExp.push_back(tx_exp_t'{PT_TOKEN, PID_IN});
        pulseStart(1'b1);
        waitTxReq();
        pulseTxDone();
        tick();
`ifdef USB_TXN_RETRY_EN
        resExp.push_back(res_exp_t'{RES_OK, 3'd2});
        txExp.push_back(tx_exp_t'{PT_TOKEN, PID_IN});
        pulseRx(PID_DATA1, 1'b0);
        waitTxReq();
        pulseTxDone();
        txExp.push_back(tx_exp_t'{PT_HS, PID_ACK});
        pulseRx(PID_DATA1, 1'b1);
        waitTxReq();
        pulseTxDone();
`else
        resExp.push_back(res_exp_t'{RES_BAD, 3'd1});
        pulseRx(PID_DATA1, 1'b0);
`endif
        waitIdle();

        // OUT answered by NAK, then by an unexpected PID
        $display("[TB] OUT transaction NAK and bad PID");
        outFailing(PID_NAK, RES_NAK);
        outFailing(PID_DATA0, RES_BAD);

        // OUT with no response: timeout after TIMEOUT_CYC idle cycles
        $display("[TB] OUT transaction timeout");
`ifdef USB_TXN_RETRY_EN
        resExp.push_back(res_exp_t'{RES_TIMEOUT, 3'd4});
        pulseStart(1'b0);
        for (int a = 0; a < 3; a++) outAttempt();
`else
        resExp.push_back(res_exp_t'{RES_TIMEOUT, 3'd1});
        pulseStart(1'b0);
`endif
        outAttempt();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (result_valid) break;
            n++;
        end
        checkOutput("timeout_latency", 32'(n), 32'd201);
        tick();
        waitIdle();

        // start while busy is ignored; reset in RX_WAIT aborts silently
        $display("[TB] busy start and mid-transaction reset");
        txExp.push_back(tx_exp_t'{PT_TOKEN, PID_IN});
        pulseStart(1'b1);
        waitTxReq();
        pulseStart(1'b0);
        @(negedge clk);
        checkOutput("busy_start_tries", 32'(tries), 32'd1);
        checkOutput("busy_start_pid", 32'(tx_pid), 32'(PID_IN));
        tick();
        pulseTxDone();
        @(negedge clk);
        checkOutput("in_rxwait_rw", 32'(rw), 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rw", 32'(rw), 32'd1);
        checkOutput("abort_result_valid", 32'(result_valid), 32'd0);
        checkOutput("abort_tries", 32'(tries), 32'd0);
        tick();
        rst_b = 1'b0;
        repeat (5) tick();

        checkOutput("tx_queue_left", 32'(txExp.size()), 32'd0);
        checkOutput("res_queue_left", 32'(resExp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
